// File: rtl/shift_sequencer_if.sv
// Request/result bus for the shift sequencer: a valid/ready request channel
// carrying op, operand and amount, and a valid/ready result channel.
interface shift_sequencer_if #(
   parameter int N = 16,
   parameter int C = 4
);
   logic         in_valid;
   logic         in_ready;
   logic [1:0]   op;
   logic [N-1:0] data_in;
   logic [C-1:0] cnt;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] data_out;
   logic         busy;

   modport master (
      output in_valid, op, data_in, cnt, out_ready,
      input  in_ready, out_valid, data_out, busy
   );

   modport slave (
      input  in_valid, op, data_in, cnt, out_ready,
      output in_ready, out_valid, data_out, busy
   );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle rotate/shift unit: one bit per cycle, result held in DONE
// until the consumer takes it. Expects 2**C == N and a matching bus.
module shift_sequencer #(
   parameter int N = 16,
   parameter int C = 4
) (
   input logic               clk,
   input logic               rst,
   shift_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [C-1:0] CNT_ONE = C'(1);

   state_t       state, state_next;
   logic [N-1:0] acc, acc_next;
   logic [C-1:0] remaining, remaining_next;
   logic [1:0]   op_q, op_q_next;

   function automatic logic [N-1:0] step(input logic [1:0] kind, input logic [N-1:0] value);
      logic [N-1:0] result;
      case (kind)
         2'b00:   result = {value[N-2:0], value[N-1]};
         2'b01:   result = {value[0], value[N-1:1]};
         2'b10:   result = {value[N-2:0], 1'b0};
         default: result = {1'b0, value[N-1:1]};
      endcase
      return result;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         remaining <= '0;
         op_q      <= 2'b00;
      end else begin
         state     <= state_next;
         acc       <= acc_next;
         remaining <= remaining_next;
         op_q      <= op_q_next;
      end
   end

   // A zero amount skips SHIFT entirely so the result appears one edge after accept.
   always_comb begin
      state_next     = state;
      acc_next       = acc;
      remaining_next = remaining;
      op_q_next      = op_q;
      case (state)
         IDLE: begin
            if (bus.in_valid) begin
               acc_next       = bus.data_in;
               remaining_next = bus.cnt;
               op_q_next      = bus.op;
               state_next     = (bus.cnt == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            acc_next       = step(op_q, acc);
            remaining_next = remaining - CNT_ONE;
            if (remaining == CNT_ONE) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.busy      = (state != IDLE);
   assign bus.data_out  = acc;

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The module SHALL have parameter N, default 16, giving the data width in bits.
REQ-002 The module SHALL have parameter C, default 4, giving the count width in bits; 2^C SHALL equal N.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port in_valid, input, 1 bit: a request is present.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 The module SHALL have port op, input, 2 bits: 00 rotate left, 01 rotate right, 10 shift left logical, 11 shift right logical.
REQ-008 The module SHALL have port data_in, input, N bits: the operand.
REQ-009 The module SHALL have port cnt, input, C bits: the shift/rotate amount, 0..N-1.
REQ-010 The module SHALL have port out_valid, output, 1 bit: data_out holds a result.
REQ-011 The module SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 The module SHALL have port data_out, output, N bits: the result register.
REQ-013 The module SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-015 in_ready SHALL be 1 in IDLE and 0 in SHIFT and DONE, decoded from state only.
REQ-016 A request SHALL be accepted on a rising edge with in_valid=1 and in_ready=1; on acceptance the block SHALL capture data_in into acc, cnt into remaining, and op into op_q.
REQ-017 On acceptance with cnt=0, the next state SHALL be DONE with acc=data_in; otherwise the next state SHALL be SHIFT.
REQ-018 In SHIFT, each cycle SHALL apply exactly one 1-bit step of op_q to acc and decrement remaining.
REQ-019 A 1-bit step SHALL be: rotate left {acc[N-2:0],acc[N-1]}; rotate right {acc[0],acc[N-1:1]}; shift left logical {acc[N-2:0],0}; shift right logical {0,acc[N-1:1]}.
REQ-020 The FSM SHALL go SHIFT->DONE on the edge where remaining=1 is decremented to 0.
REQ-021 In DONE, out_valid SHALL be 1 and data_out SHALL equal acc.
REQ-022 The result SHALL first be visible cnt+1 cycles after the acceptance edge; cnt=0 gives 1 cycle and cnt=N-1 gives N cycles.
REQ-023 In DONE with out_ready=0, data_out and out_valid SHALL hold stable indefinitely.
REQ-024 In DONE with out_ready=1, the next state SHALL be IDLE and out_valid SHALL be 0 the following cycle.
REQ-025 There SHALL be no accept in the same cycle as the out_ready handshake; the minimum request-to-request spacing is cnt+2 cycles.
REQ-026 Changes on in_valid, op, data_in and cnt SHALL be ignored outside IDLE.
REQ-027 out_ready SHALL be ignored outside DONE.
REQ-028 All outputs SHALL be registered or decoded from registered state only, with no combinational path from any input to any output.

Reset
REQ-029 rst=1 on a rising edge SHALL force state=IDLE, acc=0, remaining=0 and op_q=00, taking priority over all other inputs.
REQ-030 Immediately after reset, outputs SHALL be: in_ready=1, out_valid=0, busy=0, data_out=0.
REQ-031 A reset asserted in SHIFT or DONE SHALL abandon the operation, with no out_valid pulse for it.
REQ-032 A request with in_valid=1 in the reset cycle SHALL NOT be accepted.

Verification
REQ-033 Scenario: op=00, data_in=0x8001, cnt=1, out_ready=1 -> out_valid 2 cycles after accept, data_out=0x0003.
REQ-034 Scenario: op=01, data_in=0x0001, cnt=4 -> out_valid at accept+5, data_out=0x1000; busy high for 5 cycles.
REQ-035 Scenario: op=10, data_in=0xFFFF, cnt=15 -> data_out=0x8000 at accept+16; then op=11, data_in=0xFFFF, cnt=15 -> data_out=0x0001.
REQ-036 Scenario: op=11, data_in=0xA5A5, cnt=0 -> out_valid at accept+1, data_out=0xA5A5.
REQ-037 Scenario: result ready with out_ready=0 for 3 cycles while data_in and cnt toggle -> data_out held, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-038 Scenario: rst=1 at accept+2 of a cnt=8 request -> next cycle state IDLE, data_out=0, out_valid=0; no result ever appears for that request.
